// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpn_pkg
// Description : Shared types and constants for the RPN expression sequencer:
//               token kinds, ALU opcodes and controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package rpn_pkg;

   // Token kinds carried on tok_kind
   typedef enum logic [1:0] {
      TOK_OPND = 2'b00,
      TOK_ADD  = 2'b01,
      TOK_MUL  = 2'b10,
      TOK_END  = 2'b11
   } tok_kind_e;

   // ALU opcodes
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

   // Controller states
   typedef enum logic [3:0] {
      ST_RST_FLUSH = 4'd0,
      ST_IDLE      = 4'd1,
      ST_PUSH      = 4'd2,
      ST_OP        = 4'd3,
      ST_CAPTURE   = 4'd4,
      ST_POP2      = 4'd5,
      ST_PUSHRES   = 4'd6,
      ST_DRAIN     = 4'd7,
      ST_EMIT      = 4'd8,
      ST_DISCARD   = 4'd9
   } state_e;

endpackage : rpn_pkg
`default_nettype wire

// File: rtl/rpn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rpn_sequencer
// Description : Evaluates postfix integer expressions by sequencing an
//               external stack-based ALU. Accepts operand/add/mul/end tokens,
//               collapses the ALU stack after each operator and returns one
//               result per expression. Flushes the (reset-less) ALU stack
//               after every reset.
//               Build option RPN_SEQ_MUL_EN: when defined, multiply tokens
//               are executed with the ALU multiply opcode; otherwise they
//               mark the expression as malformed.
// Revision    : 1.0 - initial release
// ============================================================================
module rpn_sequencer
   import rpn_pkg::*;
#(
   parameter int STACK_DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tok_valid,
   output logic        tok_ready,
   input  logic [1:0]  tok_kind,
   input  logic [31:0] tok_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_overflow,
   output logic        res_error,
   output logic [31:0] alu_input_data,
   output logic [2:0]  alu_opcode,
   input  logic [31:0] alu_output_data,
   input  logic        alu_overflow,
   input  logic        alu_invalid
);

   localparam logic [10:0] c_full = 11'(STACK_DEPTH);

   state_e      r_state;
   state_e      w_next;
   logic [10:0] r_depth;
   logic [10:0] r_flush;
   logic [31:0] r_last;
   logic        r_err;
   logic        r_ovf;
   logic        w_tok_ready;
   logic [2:0]  w_opcode;
   logic [31:0] w_in;
   logic        w_accept;

`ifdef RPN_SEQ_MUL_EN
   logic        r_is_mul;
`endif

   assign w_accept = tok_valid & w_tok_ready;

   // State register; reset restarts the ALU flush from any state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RST_FLUSH;
      end else begin
         r_state <= w_next;
      end
   end

   // Depth counter, flush counter, shadow of last pushed value, sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_depth <= 11'd0;
         r_flush <= c_full;
         r_last  <= 32'd0;
         r_err   <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef RPN_SEQ_MUL_EN
         r_is_mul <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_RST_FLUSH: r_flush <= r_flush - 11'd1;
            ST_IDLE: begin
               if (w_accept) begin
                  case (tok_kind)
                     TOK_OPND: begin
                        if (r_depth == c_full) r_err  <= 1'b1;
                        else                   r_last <= tok_data;
                     end
                     TOK_ADD: begin
                        if (r_depth < 11'd2) r_err <= 1'b1;
`ifdef RPN_SEQ_MUL_EN
                        r_is_mul <= 1'b0;
`endif
                     end
                     TOK_MUL: begin
`ifdef RPN_SEQ_MUL_EN
                        if (r_depth < 11'd2) r_err <= 1'b1;
                        r_is_mul <= 1'b1;
`else
                        r_err <= 1'b1;
`endif
                     end
                     default: begin
                        // End token: a well-formed expression leaves exactly one value
                        if (r_depth != 11'd1) r_err <= 1'b1;
                     end
                  endcase
               end
            end
            ST_PUSH:    r_depth <= r_depth + 11'd1;
            ST_CAPTURE: begin
               r_last  <= alu_output_data;
               r_ovf   <= r_ovf | alu_overflow;
               r_err   <= r_err | alu_invalid;
               r_depth <= r_depth - 11'd1;
            end
            ST_POP2:    r_depth <= r_depth - 11'd1;
            ST_PUSHRES: r_depth <= r_depth + 11'd1;
            ST_DRAIN:   r_depth <= r_depth - 11'd1;
            ST_EMIT: begin
               if (res_ready) begin
                  r_err <= 1'b0;
                  r_ovf <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state decode and Moore ALU command/handshake outputs
   always_comb begin
      w_next      = r_state;
      w_tok_ready = 1'b0;
      w_opcode    = OP_NOP;
      w_in        = 32'd0;
      case (r_state)
         ST_RST_FLUSH: begin
            w_opcode = OP_POP;
            if (r_flush == 11'd1) w_next = ST_IDLE;
         end
         ST_IDLE: begin
            w_tok_ready = 1'b1;
            if (tok_valid) begin
               case (tok_kind)
                  TOK_OPND: w_next = (r_depth == c_full) ? ST_DISCARD : ST_PUSH;
                  TOK_ADD:  w_next = (r_depth >= 11'd2) ? ST_OP : ST_DISCARD;
`ifdef RPN_SEQ_MUL_EN
                  TOK_MUL:  w_next = (r_depth >= 11'd2) ? ST_OP : ST_DISCARD;
`else
                  TOK_MUL:  w_next = ST_DISCARD;
`endif
                  default:  w_next = (r_depth == 11'd0) ? ST_EMIT : ST_DRAIN;
               endcase
            end
         end
         ST_PUSH: begin
            w_opcode = OP_PUSH;
            w_in     = r_last;
            w_next   = ST_IDLE;
         end
         ST_OP: begin
`ifdef RPN_SEQ_MUL_EN
            w_opcode = r_is_mul ? OP_MUL : OP_ADD;
`else
            w_opcode = OP_ADD;
`endif
            w_next   = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_opcode = OP_POP;
            w_next   = ST_POP2;
         end
         ST_POP2: begin
            w_opcode = OP_POP;
            w_next   = ST_PUSHRES;
         end
         ST_PUSHRES: begin
            w_opcode = OP_PUSH;
            w_in     = r_last;
            w_next   = ST_IDLE;
         end
         ST_DRAIN: begin
            w_opcode = OP_POP;
            if (r_depth == 11'd1) w_next = ST_EMIT;
         end
         ST_EMIT: begin
            if (res_ready) w_next = ST_IDLE;
         end
         ST_DISCARD: begin
            w_tok_ready = 1'b1;
            if (tok_valid && (tok_kind == TOK_END))
               w_next = (r_depth == 11'd0) ? ST_EMIT : ST_DRAIN;
         end
         default: w_next = ST_RST_FLUSH;
      endcase
   end

   // The ALU has no reset, so keep it idle while reset is held; the flush
   // pop count therefore starts on the first cycle after reset releases.
   assign alu_opcode     = rst ? OP_NOP : w_opcode;
   assign alu_input_data = rst ? 32'd0  : w_in;
   assign tok_ready      = w_tok_ready;

   assign res_valid    = (r_state == ST_EMIT);
   assign res_data     = (res_valid && !r_err) ? r_last : 32'd0;
   assign res_overflow = res_valid & r_ovf;
   assign res_error    = res_valid & r_err;

endmodule : rpn_sequencer
`default_nettype wire

// File: tb/tb_rpn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rpn_sequencer
// Description : Self-checking bench for rpn_sequencer with a behavioural
//               stack ALU model alongside it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rpn_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        tok_valid;
   logic        tok_ready;
   logic [1:0]  tok_kind;
   logic [31:0] tok_data;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_overflow;
   logic        res_error;
   logic [31:0] alu_input_data;
   logic [2:0]  alu_opcode;
   logic [31:0] alu_output_data = 32'd0;
   logic        alu_overflow    = 1'b0;
   logic        alu_invalid     = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rpn_sequencer #(.STACK_DEPTH(1024)) dut (
      .clk             (clk),
      .rst             (rst),
      .tok_valid       (tok_valid),
      .tok_ready       (tok_ready),
      .tok_kind        (tok_kind),
      .tok_data        (tok_data),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_data        (res_data),
      .res_overflow    (res_overflow),
      .res_error       (res_error),
      .alu_input_data  (alu_input_data),
      .alu_opcode      (alu_opcode),
      .alu_output_data (alu_output_data),
      .alu_overflow    (alu_overflow),
      .alu_invalid     (alu_invalid)
   );

   // Behavioural stack ALU; starts with stale entries to exercise the flush
   logic [31:0]        stk [0:1023];
   int                 sp = 37;
   int                 pop_cnt = 0;
   logic [2:0]         oplog [$];
   logic               mul_seen = 1'b0;
   logic               res_seen = 1'b0;
   logic [31:0]        ma, mb, ms;
   logic signed [63:0] ea, eb, ep;

   always @(posedge clk) begin
      if (res_valid) res_seen = 1'b1;
      if (alu_opcode != 3'b000) oplog.push_back(alu_opcode);
      case (alu_opcode)
         3'b110: if (sp < 1024) begin stk[sp] = alu_input_data; sp = sp + 1; end
         3'b111: begin pop_cnt = pop_cnt + 1; if (sp > 0) sp = sp - 1; end
         3'b100: begin
            if (sp >= 2) begin
               ma = stk[sp-1]; mb = stk[sp-2]; ms = ma + mb;
               alu_output_data <= ms;
               alu_overflow    <= (ma[31] == mb[31]) && (ms[31] != ma[31]);
               alu_invalid     <= 1'b0;
            end else alu_invalid <= 1'b1;
         end
         3'b101: begin
            mul_seen = 1'b1;
            if (sp >= 2) begin
               ma = stk[sp-1]; mb = stk[sp-2];
               ea = {{32{ma[31]}}, ma}; eb = {{32{mb[31]}}, mb}; ep = ea * eb;
               alu_output_data <= ep[31:0];
               alu_overflow    <= (ep != {{32{ep[31]}}, ep[31:0]});
               alu_invalid     <= 1'b0;
            end else alu_invalid <= 1'b1;
         end
         default: ;
      endcase
   end

   task automatic send_tok(input logic [1:0] k, input logic [31:0] d);
      int n = 0;
      tok_valid = 1'b1; tok_kind = k; tok_data = d;
      while (tok_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
      if (n >= 5000) begin
         checks++; errors++;
         $display("FAIL tok_accept_timeout: tok_ready=%b required 1", tok_ready);
      end
      @(posedge clk); #1;
      tok_valid = 1'b0;
   endtask

   task automatic get_result(output logic [31:0] d, output logic o, output logic e);
      int n = 0;
      while (res_valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL result_timeout: res_valid=%b required 1", res_valid);
      end
      d = res_data; o = res_overflow; e = res_error;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic wait_flush();
      int n = 0;
      while (tok_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      checks++;
      if (tok_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_timeout: tok_ready=%b required 1", tok_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tok_valid = 1'b0; tok_kind = 2'b00; tok_data = 32'd0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tok_ready !== 1'b0)   begin errors++; $display("FAIL rst_tok_ready: got %b required 0", tok_ready); end
      checks++; if (res_valid !== 1'b0)   begin errors++; $display("FAIL rst_res_valid: got %b required 0", res_valid); end
      checks++; if (res_data !== 32'd0)   begin errors++; $display("FAIL rst_res_data: got %h required 0", res_data); end
      checks++; if (res_overflow !== 1'b0) begin errors++; $display("FAIL rst_res_overflow: got %b required 0", res_overflow); end
      checks++; if (res_error !== 1'b0)   begin errors++; $display("FAIL rst_res_error: got %b required 0", res_error); end
      checks++; if (alu_opcode !== 3'b000) begin errors++; $display("FAIL rst_alu_opcode: got %b required 000", alu_opcode); end
      checks++; if (alu_input_data !== 32'd0) begin errors++; $display("FAIL rst_alu_input: got %h required 0", alu_input_data); end
      @(negedge clk); rst = 1'b0; pop_cnt = 0;
      wait_flush();
      checks++; if (pop_cnt != 1024) begin errors++; $display("FAIL flush_pops: got %0d required 1024", pop_cnt); end
      checks++; if (sp != 0) begin errors++; $display("FAIL flush_alu_empty: sp %0d required 0", sp); end
   endtask

   task automatic test_add();
      logic [31:0] d; logic o, e;
      logic [2:0]  exp_ops [7] = '{3'b110, 3'b110, 3'b100, 3'b111, 3'b111, 3'b110, 3'b111};
      oplog.delete();
      send_tok(2'b00, 32'd3); send_tok(2'b00, 32'd4); send_tok(2'b01, 32'd0); send_tok(2'b11, 32'd0);
      get_result(d, o, e);
      checks++; if (d !== 32'd7) begin errors++; $display("FAIL add_data: got %0d required 7", d); end
      checks++; if (o !== 1'b0)  begin errors++; $display("FAIL add_ovf: got %b required 0", o); end
      checks++; if (e !== 1'b0)  begin errors++; $display("FAIL add_err: got %b required 0", e); end
      checks++;
      if (oplog.size() != 7) begin
         errors++; $display("FAIL add_op_count: got %0d ops required 7", oplog.size());
      end else begin
         for (int i = 0; i < 7; i++)
            if (oplog[i] !== exp_ops[i]) begin
               errors++; $display("FAIL add_op_seq[%0d]: got %b required %b", i, oplog[i], exp_ops[i]);
            end
      end
      checks++; if (sp != 0) begin errors++; $display("FAIL add_alu_empty: sp %0d required 0", sp); end
   endtask

   task automatic test_mul();
      logic [31:0] d; logic o, e;
      mul_seen = 1'b0;
      send_tok(2'b00, 32'd2); send_tok(2'b00, 32'd3); send_tok(2'b00, 32'd4);
      send_tok(2'b10, 32'd0); send_tok(2'b01, 32'd0); send_tok(2'b11, 32'd0);
      get_result(d, o, e);
`ifdef RPN_SEQ_MUL_EN
      checks++; if (d !== 32'd14) begin errors++; $display("FAIL mul_data: got %0d required 14", d); end
      checks++; if (e !== 1'b0)   begin errors++; $display("FAIL mul_err: got %b required 0", e); end
`else
      checks++; if (d !== 32'd0)  begin errors++; $display("FAIL mul_dis_data: got %0d required 0", d); end
      checks++; if (e !== 1'b1)   begin errors++; $display("FAIL mul_dis_err: got %b required 1", e); end
      checks++; if (mul_seen !== 1'b0) begin errors++; $display("FAIL mul_dis_opcode: mul seen %b required 0", mul_seen); end
`endif
      checks++; if (sp != 0) begin errors++; $display("FAIL mul_alu_empty: sp %0d required 0", sp); end
   endtask

   task automatic test_overflow();
      logic [31:0] d; logic o, e;
      send_tok(2'b00, 32'h7FFF_FFFF); send_tok(2'b00, 32'd1); send_tok(2'b01, 32'd0); send_tok(2'b11, 32'd0);
      get_result(d, o, e);
      checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL ovf_data: got %h required 80000000", d); end
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", o); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL ovf_err: got %b required 0", e); end
   endtask

   task automatic test_underflow();
      logic [31:0] d; logic o, e;
      send_tok(2'b01, 32'd0); send_tok(2'b00, 32'd5); send_tok(2'b11, 32'd0);
      get_result(d, o, e);
      checks++; if (e !== 1'b1)  begin errors++; $display("FAIL uflow_err: got %b required 1", e); end
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL uflow_data: got %0d required 0", d); end
      send_tok(2'b00, 32'd1); send_tok(2'b00, 32'd1); send_tok(2'b01, 32'd0); send_tok(2'b11, 32'd0);
      get_result(d, o, e);
      checks++; if (d !== 32'd2) begin errors++; $display("FAIL uflow_next_data: got %0d required 2", d); end
      checks++; if (e !== 1'b0)  begin errors++; $display("FAIL uflow_next_err: got %b required 0", e); end
      checks++; if (o !== 1'b0)  begin errors++; $display("FAIL uflow_next_ovf: got %b required 0", o); end
   endtask

   task automatic test_depth_err();
      logic [31:0] d; logic o, e;
      send_tok(2'b00, 32'd1); send_tok(2'b00, 32'd2);
      pop_cnt = 0;
      send_tok(2'b11, 32'd0);
      get_result(d, o, e);
      checks++; if (e !== 1'b1)   begin errors++; $display("FAIL depth_err: got %b required 1", e); end
      checks++; if (d !== 32'd0)  begin errors++; $display("FAIL depth_data: got %0d required 0", d); end
      checks++; if (pop_cnt != 2) begin errors++; $display("FAIL depth_pops: got %0d required 2", pop_cnt); end
      send_tok(2'b00, 32'd10); send_tok(2'b00, 32'hFFFF_FFEC); send_tok(2'b01, 32'd0); send_tok(2'b11, 32'd0);
      get_result(d, o, e);
      checks++; if (d !== 32'hFFFF_FFF6) begin errors++; $display("FAIL depth_next_data: got %h required fffffff6", d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL depth_next_err: got %b required 0", e); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      res_ready = 1'b1;
      send_tok(2'b00, 32'd4); send_tok(2'b11, 32'd0);
      while (res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++; if (res_data !== 32'd4) begin errors++; $display("FAIL b2b_data: got %0d required 4", res_data); end
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_single_cycle: res_valid %b required 0", res_valid); end
      checks++; if (tok_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: tok_ready %b required 1", tok_ready); end
      res_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      logic [31:0] d; logic o, e;
      send_tok(2'b00, 32'd5); send_tok(2'b00, 32'd6);
      @(negedge clk); rst = 1'b1; res_seen = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (alu_opcode !== 3'b000) begin errors++; $display("FAIL mrst_opcode: got %b required 000", alu_opcode); end
      checks++; if (tok_ready !== 1'b0) begin errors++; $display("FAIL mrst_tok_ready: got %b required 0", tok_ready); end
      @(negedge clk); rst = 1'b0; pop_cnt = 0;
      wait_flush();
      checks++; if (pop_cnt != 1024) begin errors++; $display("FAIL mrst_pops: got %0d required 1024", pop_cnt); end
      checks++; if (sp != 0) begin errors++; $display("FAIL mrst_alu_empty: sp %0d required 0", sp); end
      checks++; if (res_seen !== 1'b0) begin errors++; $display("FAIL mrst_no_result: res seen %b required 0", res_seen); end
      send_tok(2'b00, 32'd9); send_tok(2'b11, 32'd0);
      get_result(d, o, e);
      checks++; if (d !== 32'd9) begin errors++; $display("FAIL mrst_next_data: got %0d required 9", d); end
      checks++; if (e !== 1'b0)  begin errors++; $display("FAIL mrst_next_err: got %b required 0", e); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_overflow();
      test_underflow();
      test_depth_err();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rpn_sequencer
`default_nettype wire

// File: doc/rpn_sequencer.md
# rpn_sequencer

Controller that evaluates postfix (RPN) integer expressions by sequencing the stack-based ALU. It accepts a token stream (operand / add / multiply / end) over a valid-ready handshake and drives the ALU's `input_data`/`opcode` ports. It reads back the ALU's `output_data`/`overflow`/`invalid`, collapses operands after each operator, and returns one result per expression. It sits between the expression source and the ALU instance in the top-level wrapper.

## Interface
- `STACK_DEPTH`, 1024: ALU stack capacity; also the number of pops issued by the post-reset flush.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `tok_valid` in 1: token present.
- `tok_ready` out 1: token accepted when both high.
- `tok_kind` in 2: token kind; 00 operand, 01 add, 10 multiply, 11 end.
- `tok_data` in 32: signed operand, used only for kind 00.
- `res_valid` out 1: result held until accepted.
- `res_ready` in 1: result consumer ready.
- `res_data` out 32: signed expression value.
- `res_overflow` out 1: sticky OR of ALU overflow over the expression.
- `res_error` out 1: expression malformed or ALU reported invalid.
- `alu_input_data` out 32: drives ALU `input_data`.
- `alu_opcode` out 3: drives ALU `opcode`; 000 = NOP.
- `alu_output_data` in 32: from ALU.
- `alu_overflow` in 1: from ALU.
- `alu_invalid` in 1: from ALU.

## Operation
- The ALU has no reset. After `rst` the controller enters RST_FLUSH and issues `STACK_DEPTH` pops (111), so the ALU is empty regardless of its prior index. `tok_ready`=0 during the flush.
- States:
  - RST_FLUSH
  - IDLE
  - PUSH
  - OP
  - CAPTURE
  - POP2
  - PUSHRES
  - DRAIN
  - EMIT
  - DISCARD
- The controller tracks the stack depth itself in an 11-bit counter, plus a shadow register `last` holding the most recently pushed value.
- **Operand** (IDLE→PUSH): PUSH drives opcode 110 with the operand, then depth+1 and `last`=operand. If depth==`STACK_DEPTH`, no push is issued, error is set, and the FSM goes to DISCARD.
- **Add/mul** (IDLE→OP): requires depth≥2; otherwise error is set and the FSM goes to DISCARD.
  - OP drives 100/101.
  - CAPTURE latches `alu_output_data` into `last`, ORs `alu_overflow` into the sticky flag, sets error if `alu_invalid`, and drives 111.
  - POP2 drives 111.
  - PUSHRES drives 110 with `last`.
  - Net depth change is −1.
- **End** (IDLE→DRAIN): the result is `last`; error is set if depth≠1. DRAIN issues one pop per remaining depth, then goes to EMIT.
- **DISCARD**: consumes tokens with `tok_ready`=1 without issuing ALU ops, until an end token, then goes to DRAIN.
- **EMIT**: `res_valid`=1. `res_data` = `last`, or 0 if error. Outputs are held until `res_ready`. The accept then clears error and overflow and returns to IDLE.
- `alu_opcode` = 000 in every state not listed above.
- Arithmetic is 32-bit two's complement, computed entirely in the ALU; the controller does no math beyond the depth counter.

## Timing
- `alu_opcode`/`alu_input_data` are Moore outputs decoded from the state register. The ALU samples them at the end of that state's cycle; its outputs are read in the following state.
- Per-token latency, counted from the accept edge to the return to IDLE:
  - operand: 2 cycles
  - operator: 5 cycles
  - end: 1 + depth cycles to EMIT
- `tok_ready`=1 only in IDLE and DISCARD.
- `res_valid` rises on the cycle after DRAIN completes.
- Reset values:
  - `tok_ready`=0
  - `res_valid`=0
  - `res_data`=0
  - `res_overflow`=0
  - `res_error`=0
  - `alu_opcode`=000
  - `alu_input_data`=0
  - depth=0
- `rst` mid-expression aborts the expression with no result emitted and restarts RST_FLUSH.
- If `res_ready` is already high when EMIT is entered, the result is accepted in that same cycle.

## Configuration
- `RPN_SEQ_MUL_EN` defined: multiply tokens are executed via opcode 101.
- Not defined: a multiply token sets error and goes to DISCARD; opcode 101 is never driven.

## Structure
- Shared package `rpn_pkg` holds:
  - the token-kind enum
  - ALU opcode constants: OP_NOP=000, OP_ADD=100, OP_MUL=101, OP_PUSH=110, OP_POP=111
  - the state enum
- No sub-module is warranted: one FSM plus the depth counter. The ALU is instantiated beside the controller in the wrapper, not inside it.

## Test plan
- 3, 4, add, end → `res_data`=7, overflow=0, error=0; the ALU receives push, push, 100, 111, 111, 110, 111.
- 2, 3, 4, mul, add, end (MUL_EN) → 14; without MUL_EN → error=1, `res_data`=0.
- 0x7FFFFFFF, 1, add, end → `res_data`=0x80000000, `res_overflow`=1.
- add, 5, end → error=1, `res_data`=0; subsequent 1, 1, add, end → 2 with error=0.
- 1, 2, end → error=1 (depth 2); exactly 2 pops issued in DRAIN; next expression is correct.
- `rst` asserted after 5, 6 → no result; 1024 pops issued; then 9, end → 9.
